// File: rtl/cmd_arbiter.sv
// Round-robin arbiter sharing the host command path between NUM_REQ requesters.
// Issues one command at a time, runs the response timeout, hands the completion
// record back to the granted requester and enforces an idle gap between commands.
module cmd_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = 1,
  parameter int RESP_W         = 136,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [6*NUM_REQ-1:0]    req_index,
  input  logic [32*NUM_REQ-1:0]   req_argument,
  input  logic [NUM_REQ-1:0]      req_timeout_en,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic                    done_valid,
  input  logic                    done_ack,
  output logic [ID_W-1:0]         done_id,
  output logic                    done_timeout,
  output logic [RESP_W-1:0]       done_response,
  output logic                    ctrl_new_command,
  output logic [5:0]              ctrl_cmd_index,
  output logic [31:0]             ctrl_cmd_argument,
  output logic                    ctrl_timeout_en,
  output logic                    ctrl_timeout,
  input  logic                    ctrl_done,
  input  logic [RESP_W-1:0]       ctrl_response
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] GRANT_LSB = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_TOUT,
    S_REPORT,
    S_GAP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] sel_q;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic            pick_hit;
  logic [ID_W-1:0] pick_id;
  logic [5:0]      pick_index;
  logic [31:0]     pick_arg;
  logic            pick_ten;

  function automatic logic [ID_W-1:0] wrap_id(input int unsigned v);
    return ID_W'(v % NUM_REQ);
  endfunction

  // Round-robin pick: first pending requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_hit = 1'b0;
    pick_id  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      if (!pick_hit && req_valid[wrap_id(32'(rr_ptr) + off)]) begin
        pick_hit = 1'b1;
        pick_id  = wrap_id(32'(rr_ptr) + off);
      end
    end
  end

  // Select the chosen requester's command fields.
  always_comb begin
    pick_index = '0;
    pick_arg   = '0;
    pick_ten   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(pick_id) == i) begin
        pick_index = req_index[6*i +: 6];
        pick_arg   = req_argument[32*i +: 32];
        pick_ten   = req_timeout_en[i];
      end
    end
  end

  // Command sequencing FSM; all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      rr_ptr            <= '0;
      sel_q             <= '0;
      cnt               <= '0;
      gap_cnt           <= '0;
      req_grant         <= '0;
      done_valid        <= 1'b0;
      done_id           <= '0;
      done_timeout      <= 1'b0;
      done_response     <= '0;
      ctrl_new_command  <= 1'b0;
      ctrl_cmd_index    <= '0;
      ctrl_cmd_argument <= '0;
      ctrl_timeout_en   <= 1'b0;
      ctrl_timeout      <= 1'b0;
    end else begin
      req_grant        <= '0;
      ctrl_new_command <= 1'b0;
      ctrl_timeout     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_hit) begin
            req_grant         <= GRANT_LSB << pick_id;
            ctrl_cmd_index    <= pick_index;
            ctrl_cmd_argument <= pick_arg;
            ctrl_timeout_en   <= pick_ten;
            sel_q             <= pick_id;
            rr_ptr            <= wrap_id(32'(pick_id) + 1);
            state             <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ctrl_new_command <= 1'b1;
          cnt              <= '0;
          state            <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
          // A response in the timeout cycle takes priority over the timeout.
          if (ctrl_done) begin
            done_response <= ctrl_response;
            done_timeout  <= 1'b0;
            done_id       <= sel_q;
            done_valid    <= 1'b1;
            state         <= S_REPORT;
          end else if (ctrl_timeout_en && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            ctrl_timeout  <= 1'b1;
            done_timeout  <= 1'b1;
            done_response <= '0;
            done_id       <= sel_q;
            state         <= S_TOUT;
          end
        end
        S_TOUT: begin
          done_valid <= 1'b1;
          state      <= S_REPORT;
        end
        S_REPORT: begin
          if (done_ack) begin
            done_valid <= 1'b0;
            gap_cnt    <= '0;
            state      <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter: directed sequences, a vector table and randomized
// transactions checked against a transaction-level round-robin/timeout model.
module tb_cmd_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int RESP_W  = 136;
  localparam int TO      = 64;
  localparam int GAP     = 8;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [6*NUM_REQ-1:0]  req_index = '0;
  logic [32*NUM_REQ-1:0] req_argument = '0;
  logic [NUM_REQ-1:0]    req_timeout_en = '0;
  logic [NUM_REQ-1:0]    req_grant;
  logic                  done_valid;
  logic                  done_ack = 1'b0;
  logic [ID_W-1:0]       done_id;
  logic                  done_timeout;
  logic [RESP_W-1:0]     done_response;
  logic                  ctrl_new_command;
  logic [5:0]            ctrl_cmd_index;
  logic [31:0]           ctrl_cmd_argument;
  logic                  ctrl_timeout_en;
  logic                  ctrl_timeout;
  logic                  ctrl_done = 1'b0;
  logic [RESP_W-1:0]     ctrl_response = '0;

  always #5 clock = ~clock;

  cmd_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W(ID_W),
    .RESP_W(RESP_W),
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES(GAP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_index(req_index),
    .req_argument(req_argument),
    .req_timeout_en(req_timeout_en),
    .req_grant(req_grant),
    .done_valid(done_valid),
    .done_ack(done_ack),
    .done_id(done_id),
    .done_timeout(done_timeout),
    .done_response(done_response),
    .ctrl_new_command(ctrl_new_command),
    .ctrl_cmd_index(ctrl_cmd_index),
    .ctrl_cmd_argument(ctrl_cmd_argument),
    .ctrl_timeout_en(ctrl_timeout_en),
    .ctrl_timeout(ctrl_timeout),
    .ctrl_done(ctrl_done),
    .ctrl_response(ctrl_response)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int model_ptr = 0;
  int last_ack = -1;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] ten;
    int                 k;
    int                 ack;
    int                 exp_g;
    bit                 exp_to;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [RESP_W-1:0] act, input logic [RESP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [RESP_W-1:0] rand_resp();
    return {8'($urandom), $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference arbitration: lowest set bit of the request mask rotated to start at ptr.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] m, input int p);
    int unsigned dbl;
    int unsigned lsb;
    dbl = ((32'(m) << NUM_REQ) | 32'(m)) >> p;
    lsb = dbl & (~dbl + 1);
    return (p + $clog2(lsb)) % NUM_REQ;
  endfunction

  task automatic set_req(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ-1:0] ten);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_index[6*i +: 6]     = 6'($urandom);
      req_argument[32*i +: 32] = $urandom;
    end
    req_valid      = mask;
    req_timeout_en = ten;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0;
    done_ack = 1'b0;
    ctrl_done = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    model_ptr = 0;
    last_ack = -1;
  endtask

  // One full transaction: grant, issue, response or timeout, report, ack.
  task automatic run_txn(input bit hold, input int k, input int ack_delay, input int exp_g,
                         input bit exp_to, input logic [NUM_REQ-1:0] pend,
                         input logic [RESP_W-1:0] resp);
    int waited;
    int to_at;
    int dv_at;
    int j;
    bit stable;
    bit nogrant;
    logic [RESP_W-1:0] exp_resp;
    bit back_to_back;
    back_to_back = (last_ack >= 0);
    waited = 0;
    while (req_grant == '0 && waited < 300) begin
      tick();
      waited++;
    end
    if (back_to_back) check("grant_wait_after_ack", 136'(waited), 136'(GAP + 1));
    check("grant_onehot", 136'(req_grant), 136'(32'(1) << exp_g));
    check("ctrl_cmd_index", 136'(ctrl_cmd_index), 136'(req_index[6*exp_g +: 6]));
    check("ctrl_cmd_argument", 136'(ctrl_cmd_argument), 136'(req_argument[32*exp_g +: 32]));
    check("ctrl_timeout_en", 136'(ctrl_timeout_en), 136'(req_timeout_en[exp_g]));
    if (!hold) req_valid = '0;
    tick();
    check("new_command_pulse", 136'({ctrl_new_command, req_grant}), 136'({1'b1, {NUM_REQ{1'b0}}}));
    if (back_to_back) check("ack_to_cmd_spacing", 136'(cyc - last_ack >= GAP + 2), 136'(1));
    to_at = -1;
    dv_at = -1;
    for (j = 0; j < 300 && dv_at < 0; j++) begin
      ctrl_done = (j == k);
      ctrl_response = (j == k) ? resp : ~resp;
      if (ctrl_timeout && to_at < 0) to_at = j;
      if (done_valid) dv_at = j;
      if (dv_at < 0) tick();
    end
    ctrl_done = 1'b0;
    ctrl_response = rand_resp();
    check("done_valid_latency", 136'(dv_at), 136'(exp_to ? TO + 1 : k + 1));
    check("timeout_pulse_at", 136'(to_at), 136'(exp_to ? TO : -1));
    check("timeout_single_cycle", 136'(ctrl_timeout), 136'(0));
    exp_resp = exp_to ? '0 : resp;
    if (pend != '0) req_valid = pend;
    stable = 1'b1;
    nogrant = 1'b1;
    for (int d = 0; d < ack_delay; d++) begin
      if (done_valid !== 1'b1 || int'(done_id) != exp_g || done_timeout !== exp_to ||
          done_response !== exp_resp) stable = 1'b0;
      if (req_grant != '0) nogrant = 1'b0;
      tick();
    end
    if (ack_delay > 0) check("report_stable", 136'(stable), 136'(1));
    if (ack_delay > 0 && (pend != '0 || hold)) check("no_grant_in_report", 136'(nogrant), 136'(1));
    check("done_valid", 136'(done_valid), 136'(1));
    check("done_id", 136'(done_id), 136'(exp_g));
    check("done_timeout", 136'(done_timeout), 136'(exp_to));
    check("done_response", done_response, exp_resp);
    done_ack = 1'b1;
    last_ack = cyc;
    tick();
    done_ack = 1'b0;
    check("done_valid_drop", 136'(done_valid), 136'(0));
    model_ptr = (exp_g + 1) % NUM_REQ;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int g;
    logic [NUM_REQ-1:0] m;
    logic [NUM_REQ-1:0] t;
    int k;

    tbl[0] = '{mask: 2'b11, ten: 2'b00, k: 2,  ack: 1, exp_g: 0, exp_to: 1'b0};
    tbl[1] = '{mask: 2'b01, ten: 2'b01, k: 63, ack: 0, exp_g: 0, exp_to: 1'b0};
    tbl[2] = '{mask: 2'b10, ten: 2'b10, k: 64, ack: 2, exp_g: 1, exp_to: 1'b1};
    tbl[3] = '{mask: 2'b11, ten: 2'b11, k: 10, ack: 0, exp_g: 0, exp_to: 1'b0};
    tbl[4] = '{mask: 2'b11, ten: 2'b00, k: 0,  ack: 0, exp_g: 1, exp_to: 1'b0};
    tbl[5] = '{mask: 2'b10, ten: 2'b10, k: 70, ack: 1, exp_g: 1, exp_to: 1'b1};
    tbl[6] = '{mask: 2'b01, ten: 2'b00, k: 80, ack: 0, exp_g: 0, exp_to: 1'b0};

    // Reset state, checked while reset is still asserted.
    repeat (2) tick();
    check("reset_outputs", 136'({req_grant, done_valid, done_id, done_timeout, ctrl_new_command,
                                  ctrl_cmd_index, ctrl_cmd_argument, ctrl_timeout_en, ctrl_timeout}),
          136'(0));
    check("reset_done_response", done_response, '0);
    reset = 1'b1;

    // Single requester 0 with known command.
    set_req(2'b01, 2'b00);
    req_index[5:0] = 6'd17;
    req_argument[31:0] = 32'hFA74CD23;
    run_txn(1'b0, 5, 1, 0, 1'b0, '0, {8'h5A, 96'h0123_4567_89AB_CDEF_0011_2233, 32'h3BA692AF});

    // Both requesters held: alternating grants with the gap enforced.
    do_reset();
    set_req(2'b11, 2'b00);
    for (int n = 0; n < 4; n++) begin
      run_txn(1'b1, 3, 0, n % 2, 1'b0, '0, rand_resp());
    end
    req_valid = '0;

    // Slow ack with requester 0 pending throughout the report phase.
    set_req(2'b01, 2'b00);
    run_txn(1'b0, 4, 20, rr_pick(2'b01, model_ptr), 1'b0, 2'b01, rand_resp());
    run_txn(1'b0, 4, 0, 0, 1'b0, '0, rand_resp());

    // Reset in WAIT: outputs clear at once and the pointer restarts at 0.
    set_req(2'b01, 2'b00);
    w = 0;
    while (req_grant == '0 && w < 300) begin
      tick();
      w++;
    end
    check("pre_reset_grant", 136'(req_grant), 136'(2'b01));
    req_valid = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("async_reset_outputs", 136'({req_grant, done_valid, done_id, done_timeout, ctrl_new_command,
                                        ctrl_cmd_index, ctrl_cmd_argument, ctrl_timeout_en, ctrl_timeout}),
          136'(0));
    check("async_reset_response", done_response, '0);
    tick();
    reset = 1'b1;
    model_ptr = 0;
    last_ack = -1;
    set_req(2'b11, 2'b00);
    run_txn(1'b0, 7, 0, 0, 1'b0, '0, rand_resp());

    // Vector table from a fresh reset.
    do_reset();
    for (int v = 0; v < 7; v++) begin
      set_req(tbl[v].mask, tbl[v].ten);
      run_txn(1'b0, tbl[v].k, tbl[v].ack, tbl[v].exp_g, tbl[v].exp_to, '0, rand_resp());
    end

    // Randomized transactions against the reference model.
    for (int n = 0; n < 25; n++) begin
      m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      t = NUM_REQ'($urandom);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 90) : $urandom_range(0, 40);
      g = rr_pick(m, model_ptr);
      set_req(m, t);
      run_txn(1'b0, k, $urandom_range(0, 4), g, t[g] && (k >= TO), '0, rand_resp());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
